// File: rtl/cram_pkg.sv
// Shared types for the async CRAM controller: FSM states, request word and the registered pin bundle.
// Purely declarative: no latency, no backpressure.
package cram_pkg;
    localparam int CRAM_ADDR_W = 23;
    localparam int CRAM_DATA_W = 16;
    localparam int CRAM_A_W    = 6;

    typedef enum logic [2:0] {IDLE, ADDR, RD_DATA, WR_DATA, RECOVER} cram_state_e;

    typedef struct packed {
        logic                   write;
        logic [CRAM_ADDR_W-1:0] addr;
        logic [CRAM_DATA_W-1:0] wdata;
        logic [1:0]             be;
    } cram_req_t;

    typedef struct packed {
        logic [CRAM_A_W-1:0]    a;
        logic                   adv_n;
        logic                   ce0_n;
        logic                   ce1_n;
        logic                   oe_n;
        logic                   we_n;
        logic                   ub_n;
        logic                   lb_n;
        logic [CRAM_DATA_W-1:0] data_out;
    } cram_pins_t;

    localparam cram_pins_t PINS_RESET = '{a: '0, adv_n: 1'b1, ce0_n: 1'b1, ce1_n: 1'b1,
                                          oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1,
                                          data_out: '0};

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction
endpackage

// File: rtl/cram_if.sv
// Pin-level bundle between the controller and cram_connect; data_out is driven onto dq while oe_n is high.
// Wires only: no latency, no backpressure.
interface cram_if;
    logic [cram_pkg::CRAM_A_W-1:0]    a;
    logic                             clk;
    logic                             adv_n;
    logic                             cre;
    logic                             ce0_n;
    logic                             ce1_n;
    logic                             oe_n;
    logic                             we_n;
    logic                             ub_n;
    logic                             lb_n;
    logic [cram_pkg::CRAM_DATA_W-1:0] data_out;
    logic [cram_pkg::CRAM_DATA_W-1:0] data_in;

    modport ctrl (output a, clk, adv_n, cre, ce0_n, ce1_n, oe_n, we_n, ub_n, lb_n, data_out,
                  input  data_in);
    modport phy  (input  a, clk, adv_n, cre, ce0_n, ce1_n, oe_n, we_n, ub_n, lb_n, data_out,
                  output data_in);
endinterface

// File: rtl/cram_phase_timer.sv
// Loadable down-counter shared by every timed phase; done is high while the count sits at zero.
// Load takes effect on the next edge; no backpressure.
module cram_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               cnt <= '0;
        else if (load)         cnt <= load_val;
        else if (cnt != '0)    cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/cram_async_ctrl.sv
// Single-outstanding async muxed-PSRAM controller; response ADDR+RD/WR+1 cycles after accept, req_ready only in IDLE.
// Optional CRAM_PERF_EN adds read/write/busy-cycle counters.
module cram_async_ctrl
    import cram_pkg::*;
#(
    parameter int ADDR_CYCLES     = 2,
    parameter int RD_CYCLES       = 6,
    parameter int WR_CYCLES       = 6,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [CRAM_ADDR_W-1:0] req_addr,
    input  logic [CRAM_DATA_W-1:0] req_wdata,
    input  logic [1:0]             req_be,
    output logic                   rsp_valid,
    output logic                   rsp_write,
    output logic [CRAM_DATA_W-1:0] rsp_rdata,
`ifdef CRAM_PERF_EN
    output logic [31:0]            perf_reads,
    output logic [31:0]            perf_writes,
    output logic [31:0]            perf_busy_cycles,
`endif
    cram_if.ctrl                   cram
);
    localparam int MAX_CYC = max2(max2(ADDR_CYCLES, RD_CYCLES), max2(WR_CYCLES, RECOVERY_CYCLES));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    cram_state_e state_q, state_n;
    cram_req_t   req_q, req_in, req_cur;
    cram_pins_t  pins_q, pins_d;
    logic        accept, phase_done, rsp_pulse;
    logic [CNT_W-1:0] load_val;

    function automatic logic [CNT_W-1:0] phase_len(input cram_state_e s);
        case (s)
            ADDR:    return CNT_W'(ADDR_CYCLES - 1);
            RD_DATA: return CNT_W'(RD_CYCLES - 1);
            WR_DATA: return CNT_W'(WR_CYCLES - 1);
            RECOVER: return CNT_W'(RECOVERY_CYCLES - 1);
            default: return '0;
        endcase
    endfunction

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_in    = '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};
    // Pins for ADDR are registered on the accept edge, so they must come from the live inputs then.
    assign req_cur   = accept ? req_in : req_q;
    assign rsp_pulse = (state_n == RECOVER) && (state_q != RECOVER);
    assign load_val  = phase_len(state_n);

    cram_phase_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (reset),
        .load     (state_n != state_q),
        .load_val (load_val),
        .done     (phase_done)
    );

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:             if (req_valid) state_n = ADDR;
            ADDR:             if (phase_done) state_n = req_q.write ? WR_DATA : RD_DATA;
            RD_DATA, WR_DATA: if (phase_done) state_n = RECOVER;
            RECOVER:          if (phase_done) state_n = IDLE;
            default:          state_n = IDLE;
        endcase
    end

    always_comb begin
        pins_d          = PINS_RESET;
        pins_d.a        = pins_q.a;
        pins_d.data_out = pins_q.data_out;
        if (state_n == ADDR || state_n == RD_DATA || state_n == WR_DATA) begin
            pins_d.ce0_n = req_cur.addr[CRAM_ADDR_W-1];
            pins_d.ce1_n = !req_cur.addr[CRAM_ADDR_W-1];
            pins_d.ub_n  = !req_cur.be[1];
            pins_d.lb_n  = !req_cur.be[0];
        end
        case (state_n)
            IDLE: begin
                pins_d.a        = '0;
                pins_d.data_out = '0;
            end
            ADDR: begin
                pins_d.adv_n    = 1'b0;
                pins_d.a        = req_cur.addr[21:16];
                pins_d.data_out = req_cur.addr[15:0];
            end
            RD_DATA: pins_d.oe_n = 1'b0;
            WR_DATA: begin
                pins_d.we_n     = 1'b0;
                pins_d.data_out = req_cur.wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pins_q    <= PINS_RESET;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q   <= state_n;
            pins_q    <= pins_d;
            rsp_valid <= rsp_pulse;
            if (accept) req_q <= req_in;
            if (rsp_pulse) rsp_write <= req_q.write;
            if (rsp_pulse && !req_q.write) rsp_rdata <= cram.data_in;
        end
    end

`ifdef CRAM_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_reads       <= '0;
            perf_writes      <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (rsp_valid && !rsp_write) perf_reads  <= perf_reads + 32'd1;
            if (rsp_valid && rsp_write)  perf_writes <= perf_writes + 32'd1;
            if (state_q != IDLE)         perf_busy_cycles <= perf_busy_cycles + 32'd1;
        end
    end
`endif

    assign cram.a        = pins_q.a;
    assign cram.clk      = 1'b0;
    assign cram.adv_n    = pins_q.adv_n;
    assign cram.cre      = 1'b0;
    assign cram.ce0_n    = pins_q.ce0_n;
    assign cram.ce1_n    = pins_q.ce1_n;
    assign cram.oe_n     = pins_q.oe_n;
    assign cram.we_n     = pins_q.we_n;
    assign cram.ub_n     = pins_q.ub_n;
    assign cram.lb_n     = pins_q.lb_n;
    assign cram.data_out = pins_q.data_out;
endmodule

// File: tb/tb_cram_async_ctrl.sv
// Directed bench for cram_async_ctrl: default-timing instance plus a 1/1/1 fast instance.
module tb_cram_async_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write, rsp_valid, rsp_write;
    logic [22:0] req_addr;
    logic [15:0] req_wdata, rsp_rdata, mem_rdata;
    logic [1:0]  req_be;

    logic        f_req_valid, f_req_ready, f_req_write, f_rsp_valid, f_rsp_write;
    logic [22:0] f_req_addr;
    logic [15:0] f_req_wdata, f_rsp_rdata, f_mem_rdata;
    logic [1:0]  f_req_be;

`ifdef CRAM_PERF_EN
    logic [31:0] perf_reads, perf_writes, perf_busy_cycles;
    logic [31:0] f_perf_reads, f_perf_writes, f_perf_busy_cycles;
`endif

    cram_if bus ();
    cram_if f_bus ();
    assign bus.data_in   = mem_rdata;
    assign f_bus.data_in = f_mem_rdata;

    cram_async_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
`ifdef CRAM_PERF_EN
        .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_busy_cycles(perf_busy_cycles),
`endif
        .cram(bus)
    );

    cram_async_ctrl #(.ADDR_CYCLES(1), .RD_CYCLES(1), .WR_CYCLES(6), .RECOVERY_CYCLES(1)) dut_fast (
        .clk(clk), .reset(reset), .req_valid(f_req_valid), .req_ready(f_req_ready),
        .req_write(f_req_write), .req_addr(f_req_addr), .req_wdata(f_req_wdata), .req_be(f_req_be),
        .rsp_valid(f_rsp_valid), .rsp_write(f_rsp_write), .rsp_rdata(f_rsp_rdata),
`ifdef CRAM_PERF_EN
        .perf_reads(f_perf_reads), .perf_writes(f_perf_writes), .perf_busy_cycles(f_perf_busy_cycles),
`endif
        .cram(f_bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge in IDLE; returns at a negedge in IDLE. Timing assumes 2/6/6/2.
    task automatic access(input logic wr, input logic [22:0] ad, input logic [15:0] wd,
                          input logic [1:0] be, input logic [15:0] rd_exp);
        logic sel;
        sel       = ad[22];
        req_valid = 1'b1; req_write = wr; req_addr = ad; req_wdata = wd; req_be = be;
        chk("ready_idle", {31'd0, req_ready}, 1);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; req_addr = ~ad; req_wdata = ~wd; req_be = ~be; req_write = ~wr;
        for (int i = 0; i < 2; i++) begin
            chk("addr_ce0", {31'd0, bus.ce0_n}, {31'd0, sel});
            chk("addr_ce1", {31'd0, bus.ce1_n}, {31'd0, !sel});
            chk("addr_adv", {31'd0, bus.adv_n}, 0);
            chk("addr_a", {26'd0, bus.a}, {26'd0, ad[21:16]});
            chk("addr_dq", {16'd0, bus.data_out}, {16'd0, ad[15:0]});
            chk("addr_oe", {31'd0, bus.oe_n}, 1);
            chk("addr_ub", {31'd0, bus.ub_n}, {31'd0, !be[1]});
            chk("addr_lb", {31'd0, bus.lb_n}, {31'd0, !be[0]});
            chk("addr_ready", {31'd0, req_ready}, 0);
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            chk("data_ce0", {31'd0, bus.ce0_n}, {31'd0, sel});
            chk("data_adv", {31'd0, bus.adv_n}, 1);
            chk("data_oe", {31'd0, bus.oe_n}, {31'd0, wr});
            chk("data_we", {31'd0, bus.we_n}, {31'd0, !wr});
            chk("data_ub", {31'd0, bus.ub_n}, {31'd0, !be[1]});
            if (wr) chk("data_dq", {16'd0, bus.data_out}, {16'd0, wd});
            chk("data_rsp", {31'd0, rsp_valid}, 0);
            @(negedge clk);
        end
        chk("rsp_valid", {31'd0, rsp_valid}, 1);
        chk("rsp_write", {31'd0, rsp_write}, {31'd0, wr});
        chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, rd_exp});
        chk("rec_ce", {30'd0, bus.ce0_n, bus.ce1_n}, 3);
        chk("rec_oe_we", {30'd0, bus.oe_n, bus.we_n}, 3);
        chk("rec_ub_lb", {30'd0, bus.ub_n, bus.lb_n}, 3);
        chk("fixed_clk_cre", {30'd0, bus.clk, bus.cre}, 0);
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 0);
        chk("rec_ready", {31'd0, req_ready}, 0);
        @(negedge clk);
        chk("idle_ready", {31'd0, req_ready}, 1);
    endtask

    int  acc[3], rsp_at[3];
    int  idx, ridx, ready_cnt;
    bit  pending;

    initial begin
        reset = 1'b1;
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_be = '0; mem_rdata = '0;
        f_req_valid = 0; f_req_write = 0; f_req_addr = '0; f_req_wdata = '0; f_req_be = '0;
        f_mem_rdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 1);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_write, |rsp_rdata}, 0);
        chk("rst_a_dq", {10'd0, bus.a, bus.data_out}, 0);
        chk("rst_ctrl", {23'd0, bus.clk, bus.adv_n, bus.cre, bus.ce0_n, bus.ce1_n,
                         bus.oe_n, bus.we_n, bus.ub_n, bus.lb_n}, 9'b0_1_0_111111);
`ifdef CRAM_PERF_EN
        chk("rst_perf", perf_reads | perf_writes | perf_busy_cycles, 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        mem_rdata = 16'hBEEF;
        access(1'b0, 23'h012345, 16'h0000, 2'b11, 16'hBEEF);
        access(1'b1, 23'h400010, 16'hA55A, 2'b10, 16'hBEEF);
        mem_rdata = 16'h1234;
        access(1'b0, 23'h3ABCDE, 16'h0000, 2'b00, 16'h1234);

        // Back-to-back with req_valid held high: read, write, read.
        mem_rdata = 16'h5A5A;
        req_valid = 1; req_write = 0; req_addr = 23'h000100; req_wdata = 16'h1111; req_be = 2'b11;
        idx = 0; ridx = 0; ready_cnt = 0; pending = 0;
        for (int n = 0; n < 40; n++) begin
            if (pending) begin
                pending = 0;
                if (idx == 1) begin
                    req_write = 1; req_addr = 23'h400200; req_wdata = 16'h2222;
                end else if (idx == 2) begin
                    req_write = 0; req_addr = 23'h000300;
                end else begin
                    req_valid = 0;
                end
            end
            if (req_ready) ready_cnt++;
            if (rsp_valid && ridx < 3) begin
                rsp_at[ridx] = n;
                chk("b2b_rsp_write", {31'd0, rsp_write}, (ridx == 1) ? 1 : 0);
                if (ridx != 1) chk("b2b_rdata", {16'd0, rsp_rdata}, 32'h5A5A);
                ridx++;
            end
            if (req_valid && req_ready && idx < 3) begin
                acc[idx] = n;
                idx++;
                pending = 1;
            end
            @(negedge clk);
        end
        chk("b2b_accepts", idx, 3);
        chk("b2b_rsps", ridx, 3);
        chk("b2b_space01", acc[1] - acc[0], 11);
        chk("b2b_space12", acc[2] - acc[1], 11);
        chk("b2b_lat0", rsp_at[0] - acc[0], 9);
        chk("b2b_lat2", rsp_at[2] - acc[2], 9);
        chk("b2b_ready_cycles", ready_cnt, 10);

        // Reset during RD_DATA.
        mem_rdata = 16'hDEAD;
        req_valid = 1; req_write = 0; req_addr = 23'h000055; req_be = 2'b11;
        @(posedge clk); @(negedge clk);
        req_valid = 0;
        @(negedge clk); @(negedge clk);
        chk("mid_oe_low", {31'd0, bus.oe_n}, 0);
        #2 reset = 1'b1;
        #1;
        chk("mid_ctrl", {25'd0, bus.adv_n, bus.ce0_n, bus.ce1_n, bus.oe_n, bus.we_n,
                         bus.ub_n, bus.lb_n}, 7'b1111111);
        chk("mid_a_dq", {10'd0, bus.a, bus.data_out}, 0);
        chk("mid_ready", {31'd0, req_ready}, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            chk("mid_no_rsp", {30'd0, rsp_valid, req_ready}, 1);
            @(negedge clk);
        end
        chk("mid_rdata_cleared", {16'd0, rsp_rdata}, 0);

        // Five reads then three writes; writes must leave the last read data in place.
        for (int k = 0; k < 8; k++) begin
            mem_rdata = 16'h1000 + 16'(k);
            access(k >= 5, 23'h000400 + 23'(k), 16'hC000 + 16'(k), 2'b11,
                   (k >= 5) ? 16'h1004 : 16'h1000 + 16'(k));
        end
`ifdef CRAM_PERF_EN
        chk("perf_reads", perf_reads, 5);
        chk("perf_writes", perf_writes, 3);
        chk("perf_busy", perf_busy_cycles, 80);
`endif

        // 1/1/1 timing instance.
        f_mem_rdata = 16'h7E57;
        f_req_valid = 1; f_req_write = 0; f_req_addr = 23'h000777; f_req_be = 2'b11;
        chk("fast_ready", {31'd0, f_req_ready}, 1);
        @(posedge clk); @(negedge clk);
        f_req_valid = 0;
        chk("fast_addr", {29'd0, f_bus.adv_n, f_bus.oe_n, f_bus.ce0_n}, 3'b010);
        chk("fast_dq", {16'd0, f_bus.data_out}, 32'h0777);
        @(negedge clk);
        chk("fast_rd", {29'd0, f_bus.adv_n, f_bus.oe_n, f_rsp_valid}, 3'b100);
        @(negedge clk);
        chk("fast_rsp", {31'd0, f_rsp_valid}, 1);
        chk("fast_rdata", {16'd0, f_rsp_rdata}, 32'h7E57);
        chk("fast_oe_rec", {31'd0, f_bus.oe_n}, 1);
        @(negedge clk);
        chk("fast_idle", {30'd0, f_rsp_valid, f_req_ready}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cram_async_ctrl.md
Name: cram_async_ctrl

Overview:
Request/response controller that converts single-word read/write requests from core logic into asynchronous-mode, address/data-multiplexed PSRAM cycles on the cram_if bundle. It sits directly upstream of cram_connect, drives every control field of cram_if and consumes cram.data_in. It handles one access at a time, with programmable phase lengths in clock cycles.

Parameters:
ADDR_CYCLES, 2, cycles adv_n is held low with the address on dq (≥1)
RD_CYCLES, 6, cycles oe_n is held low before read data is sampled (≥1)
WR_CYCLES, 6, cycles we_n is held low with write data on dq (≥1)
RECOVERY_CYCLES, 2, cycles ce0_n and ce1_n are high between accesses (≥1)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller accepts a request this cycle
req_write  input  1  1 = write, 0 = read
req_addr  input  23  word address; bit 22 selects chip (0 → ce0_n, 1 → ce1_n)
req_wdata  input  16  write data
req_be  input  2  byte enables; [1] → ub_n, [0] → lb_n (active-low on pins)
rsp_valid  output  1  one-cycle completion pulse (reads and writes)
rsp_write  output  1  rsp_valid refers to a write
rsp_rdata  output  16  read data, valid with rsp_valid && !rsp_write
cram  interface  cram_if  drives a, clk, adv_n, cre, ce0_n, ce1_n, oe_n, we_n, ub_n, lb_n, data_out; samples data_in

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - state IDLE; req_ready=1, rsp_valid=0, rsp_write=0, rsp_rdata=0.
  - cram fields: a=0, clk=0, adv_n=1, cre=0, ce0_n=1, ce1_n=1, oe_n=1, we_n=1, ub_n=1, lb_n=1, data_out=0.
  - All cram outputs are registered.
- Fixed outputs: cram.clk=0 and cre=0 at all times (async mode only).
- dq direction rule: cram_connect drives data_out onto dq whenever oe_n=1. oe_n is therefore low only in RD_DATA.
- Handshake: a request is accepted when req_valid && req_ready. req_ready=1 only in IDLE. Address, data, be and write flag are captured on acceptance; later input changes are ignored.
- States:
  - IDLE → ADDR on acceptance.
  - ADDR: selected ce_n=0, adv_n=0, a=addr[21:16], data_out=addr[15:0], ub_n/lb_n from be. Lasts ADDR_CYCLES, then → RD_DATA or WR_DATA.
  - RD_DATA: adv_n=1, oe_n=0. Lasts RD_CYCLES. data_in is sampled into rsp_rdata on the final cycle, then → RECOVER.
  - WR_DATA: adv_n=1, we_n=0, data_out=wdata. Lasts WR_CYCLES. Final cycle → RECOVER.
  - RECOVER: both ce_n=1, oe_n=1, we_n=1, ub_n=lb_n=1. Lasts RECOVERY_CYCLES, then → IDLE.
- Response timing: rsp_valid pulses for exactly one cycle, on the cycle RECOVER is entered. rsp_rdata holds its value until the next read completes.
- Latency: acceptance to rsp_valid = ADDR_CYCLES + RD/WR_CYCLES + 1. Back-to-back period = that latency + RECOVERY_CYCLES.
- Phase counter: a single down-counter, width $clog2 of the maximum parameter + 1. It reloads on every state entry.
- Byte enables: req_be=0 still performs the full cycle timing with ub_n=lb_n=1.
- Reset mid-access: all outputs return to reset values immediately (asynchronous); no rsp_valid is issued.

Optional Feature:
- Macro: CRAM_PERF_EN.
- When defined:
  - Adds outputs perf_reads[31:0] and perf_writes[31:0], each incrementing on rsp_valid of its type.
  - Adds perf_busy_cycles[31:0], counting cycles not in IDLE.
  - All three wrap modulo 2^32 and reset to 0.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package cram_pkg:
  - cram_state_e (IDLE, ADDR, RD_DATA, WR_DATA, RECOVER).
  - CRAM_ADDR_W=23.
  - A cram_req_t struct (write, addr, wdata, be).
- One natural sub-module, cram_phase_timer: a loadable down-counter with a done flag, shared by all timed states.

Test Plan:
- Read, defaults:
  - Stimulus: req addr=0x012345, memory model returns 0xBEEF.
  - Expected: ce0_n low; a=0x01 and dq=0x2345 for 2 cycles; oe_n low 6 cycles; rsp_valid 9 cycles after acceptance with rdata=0xBEEF.
- Write, upper chip:
  - Stimulus: addr=0x400010, wdata=0xA55A, be=2'b10.
  - Expected: ce1_n low and ce0_n high; ub_n=0, lb_n=1; we_n low 6 cycles with dq=0xA55A; oe_n never low.
- Back-to-back:
  - Stimulus: req_valid held high with 3 mixed requests.
  - Expected: req_ready high only in IDLE; accepts spaced 11 cycles apart; 3 rsp pulses with correct rsp_write flags.
- Mid-access reset:
  - Stimulus: assert reset during RD_DATA.
  - Expected: all cram controls return to reset values within the same cycle (async); no rsp_valid; the next request completes normally.
- Parameter sweep:
  - Stimulus: ADDR_CYCLES=1, RD_CYCLES=1, RECOVERY_CYCLES=1.
  - Expected: read latency 3 cycles; dq is never driven while oe_n=0.
- CRAM_PERF_EN:
  - Stimulus: 5 reads and 3 writes.
  - Expected: perf_reads=5, perf_writes=3, perf_busy_cycles equals the summed access durations.
